// File: rtl/sys_trap_ctrl_pkg.sv
// Shared constants for the machine-mode system unit: CSR map, trap causes, mstatus fields, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam int unsigned MCAUSE_ILLEGAL_INSN = 2;
    localparam int unsigned MCAUSE_ECALL_M      = 11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_STAT,
        ST_M_RET
    } state_t;

    function automatic logic csr_known(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE};
    endfunction

    // func3 000 and 100 are the only encodings with no read-modify-write variant
    function automatic logic f3_legal(input logic [2:0] func3);
        return func3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/sys_trap_ctrl_if.sv
// Request/response bundle between decode, the system unit, WBU, IFU and the sim harness.
// Latency: n/a (wiring only).
// Backpressure: req_vld/req_rdy handshake on the request side; responses are unthrottled pulses.
interface sys_trap_ctrl_if #(parameter int XLEN = 64);
    logic            req_vld;
    logic            req_rdy;
    logic            op_csr;
    logic            op_ecall;
    logic            op_ebreak;
    logic            op_mret;
    logic [2:0]      func3;
    logic [11:0]     csr_addr;
    logic [4:0]      rs1_id;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] pc;
    logic [4:0]      dst_id;
    logic            dst_vld;
    logic            wb_vld;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            redirect_vld;
    logic [XLEN-1:0] redirect_pc;
    logic            ebreak_vld;

    modport master (
        output req_vld, op_csr, op_ecall, op_ebreak, op_mret, func3, csr_addr,
               rs1_id, src1, pc, dst_id, dst_vld,
        input  req_rdy, wb_vld, wb_addr, wb_data, redirect_vld, redirect_pc, ebreak_vld
    );

    modport slave (
        input  req_vld, op_csr, op_ecall, op_ebreak, op_mret, func3, csr_addr,
               rs1_id, src1, pc, dst_id, dst_vld,
        output req_rdy, wb_vld, wb_addr, wb_data, redirect_vld, redirect_pc, ebreak_vld
    );
endinterface

// File: rtl/sys_trap_ctrl_csr_regfile.sv
// M-mode CSR storage with address decode, one write port, an op read port and a vector read port.
// Latency: reads combinational, writes take effect on the next clk edge.
// Backpressure: none; writes to unknown addresses are dropped and such reads return 0.
module sys_trap_ctrl_csr_regfile
    import sys_trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'ha00001800),
    parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic            vec_sel,
    output logic [XLEN-1:0] vec_data
);

    logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (we) begin
            case (waddr)
                CSR_MSTATUS:  mstatus_q  <= wdata;
                CSR_MTVEC:    mtvec_q    <= wdata;
                CSR_MSCRATCH: mscratch_q <= wdata;
                CSR_MEPC:     mepc_q     <= wdata;
                CSR_MCAUSE:   mcause_q   <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CSR_MSTATUS:  rd_data = mstatus_q;
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MSCRATCH: rd_data = mscratch_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = mcause_q;
            default: ;
        endcase
    end

    assign vec_data = vec_sel ? mepc_q : mtvec_q;

endmodule

// File: rtl/sys_trap_ctrl.sv
// Machine-mode system unit: Zicsr ops, ecall/ebreak/mret, trap sequencing and PC redirect. Option: SYS_TRAP_ILLEGAL_EN.
// Latency: csr wb 1 cycle after accept, ecall redirect 3 cycles, mret redirect 1 cycle, ebreak pulse 1 cycle.
// Backpressure: req_rdy is high only in IDLE; wb/redirect/ebreak outputs are single-cycle pulses.
module sys_trap_ctrl
    import sys_trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'ha00001800),
    parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
    input logic          clk,
    input logic          rst_n,
    sys_trap_ctrl_if.slave bus
);

    state_t state_q, state_d;

    logic            accept;
    logic            is_ecall, is_mret, is_ebreak, is_csr, csr_illegal;
    logic [2:0]      func3_q;
    logic [11:0]     csr_addr_q;
    logic [4:0]      rs1_q, dst_id_q;
    logic [XLEN-1:0] src1_q, pc_q;
    logic            dst_vld_q, illegal_q, ebreak_q;

    logic            rf_we, vec_sel;
    logic [11:0]     rf_waddr, rd_addr;
    logic [XLEN-1:0] rf_wdata, rd_data, vec_data, opnd;
    logic            wb_vld, redirect_vld;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data, redirect_pc;

    assign accept    = bus.req_vld & bus.req_rdy;
    assign is_ecall  = bus.op_ecall;
    assign is_mret   = ~bus.op_ecall & bus.op_mret;
    assign is_ebreak = ~bus.op_ecall & ~bus.op_mret & bus.op_ebreak;
    assign is_csr    = ~bus.op_ecall & ~bus.op_mret & ~bus.op_ebreak & bus.op_csr;

`ifdef SYS_TRAP_ILLEGAL_EN
    assign csr_illegal = is_csr & (~csr_known(bus.csr_addr) | ~f3_legal(bus.func3));
`else
    assign csr_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            func3_q    <= '0;
            csr_addr_q <= '0;
            rs1_q      <= '0;
            src1_q     <= '0;
            pc_q       <= '0;
            dst_id_q   <= '0;
            dst_vld_q  <= 1'b0;
            illegal_q  <= 1'b0;
            ebreak_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ebreak_q <= accept & is_ebreak;
            if (accept) begin
                func3_q    <= bus.func3;
                csr_addr_q <= bus.csr_addr;
                rs1_q      <= bus.rs1_id;
                src1_q     <= bus.src1;
                pc_q       <= bus.pc;
                dst_id_q   <= bus.dst_id;
                dst_vld_q  <= bus.dst_vld;
                illegal_q  <= csr_illegal;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_ecall || csr_illegal) state_d = ST_T_EPC;
                    else if (is_mret)            state_d = ST_M_RET;
                    else if (is_csr)             state_d = ST_CSR;
                end
            end
            ST_T_EPC:   state_d = ST_T_CAUSE;
            ST_T_CAUSE: state_d = ST_T_STAT;
            ST_CSR, ST_T_STAT, ST_M_RET: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign opnd = func3_q[2] ? {{(XLEN-5){1'b0}}, rs1_q} : src1_q;

    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = csr_addr_q;
        rf_wdata     = '0;
        rd_addr      = csr_addr_q;
        vec_sel      = 1'b0;
        wb_vld       = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        case (state_q)
            ST_CSR: begin
                // set/clear with rs1=x0 (or zimm=0) is a pure read
                case (func3_q[1:0])
                    2'b01: begin rf_wdata = opnd;            rf_we = 1'b1;           end
                    2'b10: begin rf_wdata = rd_data | opnd;  rf_we = (rs1_q != '0);  end
                    2'b11: begin rf_wdata = rd_data & ~opnd; rf_we = (rs1_q != '0);  end
                    default: ;
                endcase
                if (f3_legal(func3_q) && dst_vld_q && (dst_id_q != '0)) begin
                    wb_vld  = 1'b1;
                    wb_addr = dst_id_q;
                    wb_data = rd_data;
                end
            end
            ST_T_EPC: begin
                rf_we    = 1'b1;
                rf_waddr = CSR_MEPC;
                rf_wdata = pc_q;
            end
            ST_T_CAUSE: begin
                rf_we    = 1'b1;
                rf_waddr = CSR_MCAUSE;
                rf_wdata = illegal_q ? XLEN'(MCAUSE_ILLEGAL_INSN) : XLEN'(MCAUSE_ECALL_M);
            end
            ST_T_STAT: begin
                rd_addr  = CSR_MSTATUS;
                rf_we    = 1'b1;
                rf_waddr = CSR_MSTATUS;
                rf_wdata = rd_data;
                rf_wdata[MSTATUS_MPIE] = rd_data[MSTATUS_MIE];
                rf_wdata[MSTATUS_MIE]  = 1'b0;
                rf_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                redirect_vld = 1'b1;
                redirect_pc  = {vec_data[XLEN-1:2], 2'b00};
            end
            ST_M_RET: begin
                rd_addr  = CSR_MSTATUS;
                rf_we    = 1'b1;
                rf_waddr = CSR_MSTATUS;
                rf_wdata = rd_data;
                rf_wdata[MSTATUS_MIE]  = rd_data[MSTATUS_MPIE];
                rf_wdata[MSTATUS_MPIE] = 1'b1;
                rf_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                vec_sel      = 1'b1;
                redirect_vld = 1'b1;
                redirect_pc  = vec_data;
            end
            default: ;
        endcase
    end

    sys_trap_ctrl_csr_regfile #(
        .XLEN        (XLEN),
        .MSTATUS_RST (MSTATUS_RST),
        .MTVEC_RST   (MTVEC_RST)
    ) u_csr_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .vec_sel  (vec_sel),
        .vec_data (vec_data)
    );

    assign bus.req_rdy      = (state_q == ST_IDLE);
    assign bus.wb_vld       = wb_vld;
    assign bus.wb_addr      = wb_addr;
    assign bus.wb_data      = wb_data;
    assign bus.redirect_vld = redirect_vld;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.ebreak_vld   = ebreak_q;

endmodule

// File: tb/tb_sys_trap_ctrl.sv
// Directed and randomized checks of sys_trap_ctrl against an architectural CSR/trap model.
module tb_sys_trap_ctrl;

    localparam logic [63:0] MSTATUS_RST = 64'ha00001800;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sys_trap_ctrl_if #(.XLEN(64)) bus();

    sys_trap_ctrl #(
        .XLEN        (64),
        .MSTATUS_RST (MSTATUS_RST),
        .MTVEC_RST   (64'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // architectural CSR state, keyed by CSR address; absent key = unimplemented CSR
    logic [63:0] mdl [int];

    logic [63:0] got_wb, got_rpc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        mdl[32'h300] = MSTATUS_RST;
        mdl[32'h305] = 64'h0;
        mdl[32'h340] = 64'h0;
        mdl[32'h341] = 64'h0;
        mdl[32'h342] = 64'h0;
    endtask

    task automatic drive_idle();
        bus.req_vld   = 1'b0;
        bus.op_csr    = 1'b0;
        bus.op_ecall  = 1'b0;
        bus.op_ebreak = 1'b0;
        bus.op_mret   = 1'b0;
        bus.func3     = '0;
        bus.csr_addr  = '0;
        bus.rs1_id    = '0;
        bus.src1      = '0;
        bus.pc        = '0;
        bus.dst_id    = '0;
        bus.dst_vld   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wb_vld"},  64'(bus.wb_vld), 64'd0);
        check({tag, "_wb_addr"}, 64'(bus.wb_addr), 64'd0);
        check({tag, "_wb_data"}, bus.wb_data, 64'd0);
        check({tag, "_redir"},   64'(bus.redirect_vld), 64'd0);
        check({tag, "_rpc"},     bus.redirect_pc, 64'd0);
        check({tag, "_ebreak"},  64'(bus.ebreak_vld), 64'd0);
    endtask

    task automatic run_op(input bit ce, input bit cm, input bit cb, input bit cc,
                          input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [63:0] s1, input logic [63:0] pcv,
                          input logic [4:0] dst, input bit dv,
                          output logic [63:0] owb, output logic [63:0] orpc);
        logic [63:0] old, opnd, nv, ms, cause, exp_rpc, exp_wb_data;
        int busy, redir_k;
        bit exp_wb, exp_eb, do_trap, known, legal, wr;
        busy = 0; redir_k = 0; exp_wb = 0; exp_eb = 0; do_trap = 0;
        cause = 0; exp_rpc = 0; exp_wb_data = 0; owb = 'x; orpc = 'x;

        // expected behaviour from the architectural rules, state updated afterwards
        if (ce) begin
            do_trap = 1; cause = 64'd11;
        end else if (cm) begin
            busy = 1; redir_k = 1; exp_rpc = mdl[32'h341];
            ms = mdl[32'h300]; ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
            mdl[32'h300] = ms;
        end else if (cb) begin
            exp_eb = 1;
        end else if (cc) begin
            known = mdl.exists(int'(addr));
            legal = (f3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111});
`ifdef SYS_TRAP_ILLEGAL_EN
            if (!known || !legal) begin
                do_trap = 1; cause = 64'd2;
            end else
`endif
            begin
                busy = 1;
                old = known ? mdl[int'(addr)] : 64'h0;
                if (legal) begin
                    exp_wb      = dv && (dst != 0);
                    exp_wb_data = old;
                    opnd = (f3 >= 3'b101) ? 64'(rs1) : s1;
                    wr = 0; nv = old;
                    case (f3)
                        3'b001, 3'b101: begin nv = opnd;        wr = 1;         end
                        3'b010, 3'b110: begin nv = old | opnd;  wr = (rs1 != 0); end
                        default:        begin nv = old & ~opnd; wr = (rs1 != 0); end
                    endcase
                    if (wr && known) mdl[int'(addr)] = nv;
                end
            end
        end
        if (do_trap) begin
            busy = 3; redir_k = 3;
            exp_rpc = mdl[32'h305] & ~64'h3;
            mdl[32'h341] = pcv;
            mdl[32'h342] = cause;
            ms = mdl[32'h300]; ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
            mdl[32'h300] = ms;
        end

        @(negedge clk);
        bus.op_ecall = ce; bus.op_mret = cm; bus.op_ebreak = cb; bus.op_csr = cc;
        bus.func3 = f3; bus.csr_addr = addr; bus.rs1_id = rs1; bus.src1 = s1;
        bus.pc = pcv; bus.dst_id = dst; bus.dst_vld = dv;
        bus.req_vld = 1'b1;
        @(posedge clk);
        #1;
        // scramble operands so anything not captured at accept shows up
        bus.req_vld = 1'b0;
        bus.src1 = {$urandom, $urandom}; bus.pc = {$urandom, $urandom};
        bus.rs1_id = 5'($urandom); bus.dst_id = 5'($urandom); bus.csr_addr = 12'($urandom);
        bus.func3 = 3'($urandom); bus.dst_vld = 1'($urandom);

        for (int k = 1; k <= busy + 1; k++) begin
            @(negedge clk);
            check($sformatf("rdy_k%0d", k), 64'(bus.req_rdy), 64'(k > busy));
            check($sformatf("wb_vld_k%0d", k), 64'(bus.wb_vld), 64'(k == 1 && exp_wb));
            if (k == 1 && exp_wb) begin
                check("wb_addr", 64'(bus.wb_addr), 64'(dst));
                check("wb_data", bus.wb_data, exp_wb_data);
                owb = bus.wb_data;
            end
            check($sformatf("redir_vld_k%0d", k), 64'(bus.redirect_vld), 64'(k == redir_k));
            if (k == redir_k) begin
                check("redir_pc", bus.redirect_pc, exp_rpc);
                orpc = bus.redirect_pc;
            end
            check($sformatf("ebreak_k%0d", k), 64'(bus.ebreak_vld), 64'(k == 1 && exp_eb));
        end
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [63:0] s1, input logic [4:0] dst, output logic [63:0] owb);
        logic [63:0] rpc;
        run_op(0, 0, 0, 1, f3, addr, rs1, s1, 64'h0, dst, 1'b1, owb, rpc);
    endtask

    initial begin
        logic [63:0] rpc;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rdy", 64'(bus.req_rdy), 64'd1);
        check_quiet("reset");

        // csrrw mtvec then read it back with csrrs x0
        csr_op(3'b001, 12'h305, 5'd7, 64'h8000_0104, 5'd5, got_wb);
        check("csrrw_mtvec_old", got_wb, 64'h0);
        csr_op(3'b010, 12'h305, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, got_wb);
        check("csrrs_mtvec_read", got_wb, 64'h8000_0104);
        csr_op(3'b010, 12'h305, 5'd0, 64'h0, 5'd6, got_wb);
        check("mtvec_unchanged", got_wb, 64'h8000_0104);

        // set MIE, then ecall
        csr_op(3'b110, 12'h300, 5'd8, 64'h0, 5'd1, got_wb);
        check("csrrsi_mstatus_old", got_wb, MSTATUS_RST);
        run_op(1, 0, 0, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0010, 5'd0, 1'b0, got_wb, rpc);
        check("ecall_redirect", rpc, 64'h8000_0104);
        csr_op(3'b010, 12'h341, 5'd0, 64'h0, 5'd2, got_wb);
        check("ecall_mepc", got_wb, 64'h8000_0010);
        csr_op(3'b010, 12'h342, 5'd0, 64'h0, 5'd2, got_wb);
        check("ecall_mcause", got_wb, 64'd11);
        csr_op(3'b010, 12'h300, 5'd0, 64'h0, 5'd2, got_wb);
        check("ecall_mstatus", got_wb, 64'ha00001880);

        run_op(0, 1, 0, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h0, 5'd0, 1'b0, got_wb, rpc);
        check("mret_redirect", rpc, 64'h8000_0010);
        csr_op(3'b010, 12'h300, 5'd0, 64'h0, 5'd3, got_wb);
        check("mret_mstatus", got_wb, 64'ha00001888);

        // csrrci mstatus zimm=8
        csr_op(3'b001, 12'h300, 5'd1, 64'ha00001808, 5'd0, got_wb);
        csr_op(3'b111, 12'h300, 5'd8, 64'h0, 5'd4, got_wb);
        check("csrrci_old", got_wb, 64'ha00001808);
        csr_op(3'b010, 12'h300, 5'd0, 64'h0, 5'd4, got_wb);
        check("csrrci_new", got_wb, 64'ha00001800);

        // unknown CSR read
        run_op(0, 0, 0, 1, 3'b010, 12'h7C0, 5'd0, 64'h0, 64'h8000_0040, 5'd9, 1'b1, got_wb, rpc);
`ifdef SYS_TRAP_ILLEGAL_EN
        check("illegal_redirect", rpc, 64'h8000_0104);
        csr_op(3'b010, 12'h342, 5'd0, 64'h0, 5'd2, got_wb);
        check("illegal_mcause", got_wb, 64'd2);
`else
        check("unknown_csr_wb", got_wb, 64'h0);
`endif

        // ebreak pulse and priority with several ops at once
        run_op(0, 0, 1, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h0, 5'd0, 1'b0, got_wb, rpc);
        run_op(0, 1, 1, 1, 3'b001, 12'h340, 5'd3, 64'h55, 64'h0, 5'd7, 1'b1, got_wb, rpc);
        run_op(1, 1, 1, 1, 3'b001, 12'h340, 5'd3, 64'h55, 64'h8000_0080, 5'd7, 1'b1, got_wb, rpc);

        // reset while in T_CAUSE
        @(negedge clk);
        bus.op_ecall = 1'b1; bus.pc = 64'h8000_0020; bus.req_vld = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check("rst_mid_epc_redir", 64'(bus.redirect_vld), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cause_redir", 64'(bus.redirect_vld), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_mid_rdy", 64'(bus.req_rdy), 64'd1);
        check_quiet("rst_mid");
        @(negedge clk);
        check("rst_mid_late_redir", 64'(bus.redirect_vld), 64'd0);
        csr_op(3'b010, 12'h342, 5'd0, 64'h0, 5'd1, got_wb);
        check("rst_mid_mcause", got_wb, 64'h0);
        csr_op(3'b010, 12'h300, 5'd0, 64'h0, 5'd1, got_wb);
        check("rst_mid_mstatus", got_wb, MSTATUS_RST);

        // randomized ops against the model
        for (int n = 0; n < 200; n++) begin
            logic [11:0] addrs [6];
            int sel;
            bit ce, cm, cb, cc;
            logic [4:0] rs1;
            addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340;
            addrs[3] = 12'h341; addrs[4] = 12'h342; addrs[5] = 12'h7C0;
            sel = $urandom_range(0, 9);
            ce = 0; cm = 0; cb = 0; cc = 0;
            if (sel < 6)       cc = 1;
            else if (sel == 6) ce = 1;
            else if (sel == 7) cm = 1;
            else if (sel == 8) cb = 1;
            else begin
                ce = 1'($urandom); cm = 1'($urandom); cb = 1'($urandom); cc = 1'($urandom);
            end
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op(ce, cm, cb, cc, 3'($urandom), addrs[$urandom_range(0, 5)], rs1,
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                   got_wb, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
